// File: rtl/timekeeper_pkg.sv
// Shared widths, default moduli and a range helper for the hh:mm:ss timekeeper.
package timekeeper_pkg;

  localparam int SEC_W       = 6;
  localparam int MIN_W       = 6;
  localparam int HR_W        = 5;
  localparam int SEC_MOD_DEF = 60;
  localparam int MIN_MOD_DEF = 60;
  localparam int HR_MOD_DEF  = 24;

  // Zero-extended operands keep the compare exact even when a modulus is 2**width.
  function automatic logic in_range(input logic [6:0] val, input logic [6:0] lim);
    return (val < lim);
  endfunction

endpackage

// File: rtl/timekeeper_hms_mod_counter.sv
// One modulo-MOD time field: counts up or down, presets, and flags a wrap so the next field can chain.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic [W-1:0] count_nxt
);

  localparam logic [W-1:0] ZERO = W'(0);
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_step;
  logic         w_at_bound;

  // One step in the selected direction, folding around the modulus.
  always_comb begin
    w_step     = r_count;
    w_at_bound = 1'b0;
    if (dir) begin
      if (r_count == ZERO) begin
        w_step     = MAXV;
        w_at_bound = 1'b1;
      end else begin
        w_step = r_count - ONE;
      end
    end else begin
      if (r_count == MAXV) begin
        w_step     = ZERO;
        w_at_bound = 1'b1;
      end else begin
        w_step = r_count + ONE;
      end
    end
  end

  // Value the field takes at the next edge; preset has priority over stepping.
  always_comb begin
    count_nxt = r_count;
    if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      count_nxt = w_step;
    end else begin
      count_nxt = r_count;
    end
  end

  // Field state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= ZERO;
    end else begin
      r_count <= count_nxt;
    end
  end

  assign count = r_count;
  assign wrap  = en & w_at_bound & ~load;

endmodule

// File: rtl/timekeeper_hms.sv
// Hours:minutes:seconds timekeeper with up/down ticking, validated preset, alarm compare and wrap pulses.
module timekeeper_hms
  import timekeeper_pkg::*;
#(
  parameter int SEC_MOD = SEC_MOD_DEF,
  parameter int MIN_MOD = MIN_MOD_DEF,
  parameter int HR_MOD  = HR_MOD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic             dir,
  input  logic             load,
  input  logic [SEC_W-1:0] load_sec,
  input  logic [MIN_W-1:0] load_min,
  input  logic [HR_W-1:0]  load_hr,
  input  logic             alm_en,
  input  logic [SEC_W-1:0] alm_sec,
  input  logic [MIN_W-1:0] alm_min,
  input  logic [HR_W-1:0]  alm_hr,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] min,
  output logic [HR_W-1:0]  hr,
  output logic             sec_wrap,
  output logic             min_wrap,
  output logic             day_wrap,
  output logic             alarm_hit,
  output logic             load_err
);

  localparam logic [6:0] SEC_LIM = 7'(SEC_MOD);
  localparam logic [6:0] MIN_LIM = 7'(MIN_MOD);
  localparam logic [6:0] HR_LIM  = 7'(HR_MOD);

  logic             w_load_ok;
  logic             w_load_acc;
  logic             w_tick;
  logic             w_sec_wrap;
  logic             w_min_wrap;
  logic             w_hr_wrap;
  logic [SEC_W-1:0] w_sec_nxt;
  logic [MIN_W-1:0] w_min_nxt;
  logic [HR_W-1:0]  w_hr_nxt;
  logic             w_alarm_match;

  logic r_sec_wrap;
  logic r_min_wrap;
  logic r_day_wrap;
  logic r_alarm_hit;
  logic r_load_err;

  assign w_load_ok  = in_range({1'b0, load_sec}, SEC_LIM) &
                      in_range({1'b0, load_min}, MIN_LIM) &
                      in_range({2'b00, load_hr}, HR_LIM);
  assign w_load_acc = load & w_load_ok;
  // Any load strobe, valid or not, swallows a tick in the same cycle.
  assign w_tick     = tick_en & ~load;

  mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_tick),
    .dir       (dir),
    .load      (w_load_acc),
    .load_val  (load_sec),
    .count     (sec),
    .wrap      (w_sec_wrap),
    .count_nxt (w_sec_nxt)
  );

  mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_sec_wrap),
    .dir       (dir),
    .load      (w_load_acc),
    .load_val  (load_min),
    .count     (min),
    .wrap      (w_min_wrap),
    .count_nxt (w_min_nxt)
  );

  mod_counter #(.MOD(HR_MOD), .W(HR_W)) u_hr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_min_wrap),
    .dir       (dir),
    .load      (w_load_acc),
    .load_val  (load_hr),
    .count     (hr),
    .wrap      (w_hr_wrap),
    .count_nxt (w_hr_nxt)
  );

  // Next time is always in range, so out-of-range alarm values can never match.
  assign w_alarm_match = (w_sec_nxt == alm_sec) & (w_min_nxt == alm_min) & (w_hr_nxt == alm_hr);

  // Single-cycle status pulses aligned with the updated time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_wrap  <= 1'b0;
      r_min_wrap  <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_alarm_hit <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_sec_wrap  <= w_sec_wrap;
      r_min_wrap  <= w_min_wrap;
      r_day_wrap  <= w_hr_wrap;
      r_alarm_hit <= w_tick & alm_en & w_alarm_match;
      r_load_err  <= load & ~w_load_ok;
    end
  end

  assign sec_wrap  = r_sec_wrap;
  assign min_wrap  = r_min_wrap;
  assign day_wrap  = r_day_wrap;
  assign alarm_hit = r_alarm_hit;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_timekeeper_hms.sv
// Directed self-checking bench for timekeeper_hms with hand-computed expected times and pulses.
module tb_timekeeper_hms;

  logic       clk;
  logic       rst_n;
  logic       tick_en;
  logic       dir;
  logic       load;
  logic [5:0] load_sec;
  logic [5:0] load_min;
  logic [4:0] load_hr;
  logic       alm_en;
  logic [5:0] alm_sec;
  logic [5:0] alm_min;
  logic [4:0] alm_hr;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic       sec_wrap;
  logic       min_wrap;
  logic       day_wrap;
  logic       alarm_hit;
  logic       load_err;

  int n_total = 0;
  int n_bad   = 0;

  timekeeper_hms dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_en   (tick_en),
    .dir       (dir),
    .load      (load),
    .load_sec  (load_sec),
    .load_min  (load_min),
    .load_hr   (load_hr),
    .alm_en    (alm_en),
    .alm_sec   (alm_sec),
    .alm_min   (alm_min),
    .alm_hr    (alm_hr),
    .sec       (sec),
    .min       (min),
    .hr        (hr),
    .sec_wrap  (sec_wrap),
    .min_wrap  (min_wrap),
    .day_wrap  (day_wrap),
    .alarm_hit (alarm_hit),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load     = 1'b1;
    load_hr  = 5'(h);
    load_min = 6'(m);
    load_sec = 6'(s);
    cyc();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_en = 1'b0; dir = 1'b0; load = 1'b0;
    load_sec = 6'd0; load_min = 6'd0; load_hr = 5'd0;
    alm_en = 1'b0; alm_sec = 6'd0; alm_min = 6'd0; alm_hr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_time", 32'({hr, min, sec}), 32'(hms(0, 0, 0)));
    check_val("rst_pulses", 32'({sec_wrap, min_wrap, day_wrap, alarm_hit, load_err}), 32'd0);

    // 60 up ticks: sec 1..59 then wrap to 0 with a carry into min
    rst_n = 1'b1;
    tick_en = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      check_val("up_time", 32'({hr, min, sec}), 32'(hms(0, i / 60, i % 60)));
      check_val("up_sec_wrap", 32'(sec_wrap), (i == 60) ? 32'd1 : 32'd0);
    end
    tick_en = 1'b0;
    cyc();
    check_val("hold_time", 32'({hr, min, sec}), 32'(hms(0, 1, 0)));
    check_val("hold_wraps", 32'({sec_wrap, min_wrap, day_wrap}), 32'd0);

    // full-day wrap upward
    do_load(23, 59, 59);
    check_val("load_time", 32'({hr, min, sec}), 32'(hms(23, 59, 59)));
    check_val("load_flags", 32'({sec_wrap, min_wrap, day_wrap, load_err}), 32'd0);
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    check_val("day_up_time", 32'({hr, min, sec}), 32'(hms(0, 0, 0)));
    check_val("day_up_wraps", 32'({sec_wrap, min_wrap, day_wrap}), 32'b111);
    cyc();
    check_val("day_up_clear", 32'({sec_wrap, min_wrap, day_wrap}), 32'd0);

    // full-day wrap downward
    do_load(0, 0, 0);
    dir = 1'b1;
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    dir = 1'b0;
    check_val("day_dn_time", 32'({hr, min, sec}), 32'(hms(23, 59, 59)));
    check_val("day_dn_wraps", 32'({sec_wrap, min_wrap, day_wrap}), 32'b111);

    // invalid load with a tick in the same cycle: both dropped
    tick_en = 1'b1;
    do_load(12, 60, 0);
    tick_en = 1'b0;
    check_val("bad_load_time", 32'({hr, min, sec}), 32'(hms(23, 59, 59)));
    check_val("bad_load_err", 32'(load_err), 32'd1);
    check_val("bad_load_wraps", 32'({sec_wrap, min_wrap, day_wrap}), 32'd0);
    cyc();
    check_val("bad_load_err_clr", 32'(load_err), 32'd0);
    do_load(5, 5, 32);
    check_val("bad_hr_ok_sec", 32'({hr, min, sec}), 32'(hms(5, 5, 32)));
    do_load(24, 0, 0);
    check_val("bad_hr_time", 32'({hr, min, sec}), 32'(hms(5, 5, 32)));
    check_val("bad_hr_err", 32'(load_err), 32'd1);

    // alarm: tick into the compare time fires, a load into it does not
    alm_en = 1'b1; alm_hr = 5'd1; alm_min = 6'd2; alm_sec = 6'd3;
    tick_en = 1'b1;
    do_load(1, 2, 2);
    check_val("prio_load_time", 32'({hr, min, sec}), 32'(hms(1, 2, 2)));
    check_val("prio_load_alarm", 32'(alarm_hit), 32'd0);
    cyc();
    tick_en = 1'b0;
    check_val("alarm_time", 32'({hr, min, sec}), 32'(hms(1, 2, 3)));
    check_val("alarm_hit", 32'(alarm_hit), 32'd1);
    cyc();
    check_val("alarm_clr", 32'(alarm_hit), 32'd0);
    do_load(1, 2, 3);
    check_val("alarm_on_load", 32'(alarm_hit), 32'd0);
    dir = 1'b1;
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    dir = 1'b0;
    check_val("dn_plain_time", 32'({hr, min, sec}), 32'(hms(1, 2, 2)));
    check_val("dn_plain_flags", 32'({sec_wrap, min_wrap, day_wrap, alarm_hit}), 32'd0);
    alm_en = 1'b0;
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    check_val("alarm_disabled", 32'(alarm_hit), 32'd0);

    // asynchronous reset mid-count with a pending load and tick
    do_load(5, 30, 10);
    tick_en = 1'b1;
    cyc();
    check_val("pre_rst_time", 32'({hr, min, sec}), 32'(hms(5, 30, 11)));
    #3;
    rst_n = 1'b0;
    load = 1'b1; load_hr = 5'd10; load_min = 6'd10; load_sec = 6'd10;
    #1;
    check_val("async_rst_time", 32'({hr, min, sec}), 32'(hms(0, 0, 0)));
    check_val("async_rst_pulses", 32'({sec_wrap, min_wrap, day_wrap, alarm_hit, load_err}), 32'd0);
    cyc();
    check_val("in_rst_time", 32'({hr, min, sec}), 32'(hms(0, 0, 0)));
    load = 1'b0;
    rst_n = 1'b1;
    cyc();
    tick_en = 1'b0;
    check_val("post_rst_time", 32'({hr, min, sec}), 32'(hms(0, 0, 1)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/timekeeper_hms.md
TIMEKEEPER_HMS -- requirements
Module: timekeeper_hms

Interface
REQ-001 SHALL have parameter SEC_MOD, default 60, seconds modulus (2..64).
REQ-002 SHALL have parameter MIN_MOD, default 60, minutes modulus (2..64).
REQ-003 SHALL have parameter HR_MOD, default 24, hours modulus (2..32).
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick_en  input  1  advance time one step this cycle.
REQ-007 SHALL have port dir  input  1  0 = count up, 1 = count down; sampled with tick_en.
REQ-008 SHALL have port load  input  1  synchronous preset strobe.
REQ-009 SHALL have ports load_sec/load_min/load_hr  input  6/6/5  preset values.
REQ-010 SHALL have ports alm_en, alm_sec/alm_min/alm_hr  input  1/6/6/5  alarm enable and compare time.
REQ-011 SHALL have ports sec/min/hr  output  6/6/5  registered current time.
REQ-012 SHALL have ports sec_wrap/min_wrap/day_wrap  output  1  registered one-cycle wrap pulses.
REQ-013 SHALL have ports alarm_hit, load_err  output  1  registered one-cycle pulses.

Function
REQ-014 Priority per cycle SHALL be: load > tick_en > hold.
REQ-015 Load SHALL be accepted only if load_sec<SEC_MOD, load_min<MIN_MOD, load_hr<HR_MOD; accepted load SHALL update all three fields next edge.
REQ-016 Out-of-range load SHALL leave time unchanged and pulse load_err for one cycle; a tick in that cycle SHALL also be dropped.
REQ-017 Up tick: sec SHALL increment; at SEC_MOD-1 it SHALL become 0 and carry into min; min at MIN_MOD-1 likewise carries into hr; hr at HR_MOD-1 wraps to 0.
REQ-018 Down tick: sec SHALL decrement; at 0 it SHALL become SEC_MOD-1 and borrow from min; min/hr likewise; hr at 0 becomes HR_MOD-1.
REQ-019 Carries SHALL ripple within the same cycle; full-day wrap (e.g. 23:59:59 -> 00:00:00) SHALL complete in one edge.
REQ-020 sec_wrap SHALL be high exactly the cycle after an edge where sec wrapped (either direction); min_wrap when min wrapped; day_wrap when hr wrapped; else 0.
REQ-021 All wrap pulses SHALL be 0 in any cycle following a hold or load edge.
REQ-022 alarm_hit SHALL pulse the cycle after a tick edge whose new time equals alm_hr:alm_min:alm_sec while alm_en=1; loads SHALL NOT trigger it.
REQ-023 Latency SHALL be one clock from tick_en/load to updated outputs; no combinational input-to-output paths.
REQ-024 Out-of-range alarm compare values SHALL simply never match.
REQ-025 tick_en held high SHALL advance one step per cycle with no lost carries.

Reset
REQ-026 rst_n low SHALL asynchronously force sec=min=hr=0 and all pulse outputs=0.
REQ-027 Reset asserted mid-operation SHALL discard any pending load or tick; first tick after release counts from 00:00:00.
REQ-028 Release SHALL be taken as synchronised externally; block adds no synchroniser.

Structure
REQ-029 Shared package timekeeper_pkg SHALL hold field widths (6,6,5) and default moduli 60/60/24.
REQ-030 Sub-module mod_counter SHALL implement one field: parameter MOD, inputs en/dir/load/load_val, outputs count and wrap; instantiated three times with en chained by wrap.
REQ-031 Top level SHALL hold load validation, alarm compare and output pulse registers.

Verification
REQ-032 Reset, 60 up ticks -> sec 59->0, min=1, sec_wrap one cycle after 60th tick only.
REQ-033 Load 23:59:59 (ok), one up tick -> 00:00:00, sec_wrap=min_wrap=day_wrap=1 for one cycle.
REQ-034 Load 00:00:00, dir=1 tick -> 23:59:59, all three wraps pulse.
REQ-035 Load 12:60:00 with tick_en=1 same cycle -> time unchanged, load_err pulse, no wraps.
REQ-036 alm_en=1, alarm 01:02:03, load 01:02:02 then tick -> alarm_hit one cycle; load 01:02:03 directly -> no alarm_hit.
REQ-037 rst_n low mid-count at 05:30:10 with tick_en=1 -> outputs 0 immediately, pulses 0, counting resumes from 0 after release.
